// File: rtl/ras_stack.sv
// rtl/ras_stack.sv - speculative return address stack with checkpoint recovery
// Outputs come from registered state only; recovery restores then replays one op in a single cycle.
module ras_stack #(
    parameter int RAS_DEPTH = 16,
    parameter int RAS_PTR_W = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 ras_valid_i,
    input  logic [1:0]           ras_ctl_i,
    input  logic [63:0]          ras_br_pc_i,
    input  logic [2:0]           ras_br_pos_i,
    output logic [63:0]          ras_tos_o,
    output logic                 ras_empty_o,
    output logic [RAS_PTR_W-1:0] ras_ckpt_ptr_o,
    output logic [RAS_PTR_W:0]   ras_ckpt_cnt_o,
    output logic [63:0]          ras_ckpt_data_o,
    input  logic                 recover_i,
    input  logic [RAS_PTR_W-1:0] recover_ptr_i,
    input  logic [RAS_PTR_W:0]   recover_cnt_i,
    input  logic [63:0]          recover_data_i,
    input  logic [1:0]           recover_ctl_i,
    input  logic [63:0]          recover_ret_i,
    input  logic                 flush_i
);

    localparam logic [RAS_PTR_W:0] CNT_MAX = (RAS_PTR_W+1)'(RAS_DEPTH);

    logic [63:0]          r_stack [RAS_DEPTH];
    logic [RAS_PTR_W-1:0] r_ptr;
    logic [RAS_PTR_W:0]   r_cnt;

    logic [63:0]          w_fetch_ret;
    logic [RAS_PTR_W-1:0] w_base_ptr;
    logic [RAS_PTR_W:0]   w_base_cnt;
    logic                 w_op_en;
    logic [1:0]           w_op_ctl;
    logic [63:0]          w_op_ret;
    logic [RAS_PTR_W-1:0] w_nxt_ptr;
    logic [RAS_PTR_W:0]   w_nxt_cnt;
    logic                 w_wr_en;
    logic [RAS_PTR_W-1:0] w_wr_idx;

    assign w_fetch_ret = ras_br_pc_i + (({61'd0, ras_br_pos_i} + 64'd1) << 2);

    assign ras_tos_o       = r_stack[r_ptr];
    assign ras_empty_o     = (r_cnt == '0);
    assign ras_ckpt_ptr_o  = r_ptr;
    assign ras_ckpt_cnt_o  = r_cnt;
    assign ras_ckpt_data_o = r_stack[r_ptr];

    // Recovery replaces both the base state and the operation being applied.
    always_comb begin
        w_base_ptr = recover_i ? recover_ptr_i : r_ptr;
        w_base_cnt = recover_i ? recover_cnt_i : r_cnt;
        w_op_en    = recover_i | ras_valid_i;
        w_op_ctl   = recover_i ? recover_ctl_i : ras_ctl_i;
        w_op_ret   = recover_i ? recover_ret_i : w_fetch_ret;
        w_nxt_ptr  = w_base_ptr;
        w_nxt_cnt  = w_base_cnt;
        w_wr_en    = 1'b0;
        w_wr_idx   = w_base_ptr;
        if (w_op_en) begin
            case (w_op_ctl)
                2'b01: begin
                    w_wr_en   = 1'b1;
                    w_wr_idx  = w_base_ptr + 1'b1;
                    w_nxt_ptr = w_base_ptr + 1'b1;
                    w_nxt_cnt = (w_base_cnt >= CNT_MAX) ? CNT_MAX : w_base_cnt + 1'b1;
                end
                2'b10: begin
                    if (w_base_cnt != '0) begin
                        w_nxt_ptr = w_base_ptr - 1'b1;
                        w_nxt_cnt = w_base_cnt - 1'b1;
                    end
                end
                2'b11: begin
                    w_wr_en   = 1'b1;
                    w_nxt_cnt = (w_base_cnt == '0) ? {{RAS_PTR_W{1'b0}}, 1'b1} : w_base_cnt;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                r_stack[i] <= '0;
            end
            r_ptr <= '0;
            r_cnt <= '0;
        end else if (flush_i) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else begin
            // The replayed op's write is ordered last so it overrides the restored entry.
            if (recover_i) begin
                r_stack[recover_ptr_i] <= recover_data_i;
            end
            if (w_wr_en) begin
                r_stack[w_wr_idx] <= w_op_ret;
            end
            r_ptr <= w_nxt_ptr;
            r_cnt <= w_nxt_cnt;
        end
    end

endmodule

// File: tb/tb_ras_stack.sv
// tb/tb_ras_stack.sv - scoreboard bench for ras_stack
// Stimulus queues expected stack state; a negedge monitor pops and compares.
module tb_ras_stack;
    localparam int PW = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          ras_valid_i;
    logic [1:0]    ras_ctl_i;
    logic [63:0]   ras_br_pc_i;
    logic [2:0]    ras_br_pos_i;
    logic [63:0]   ras_tos_o;
    logic          ras_empty_o;
    logic [PW-1:0] ras_ckpt_ptr_o;
    logic [PW:0]   ras_ckpt_cnt_o;
    logic [63:0]   ras_ckpt_data_o;
    logic          recover_i;
    logic [PW-1:0] recover_ptr_i;
    logic [PW:0]   recover_cnt_i;
    logic [63:0]   recover_data_i;
    logic [1:0]    recover_ctl_i;
    logic [63:0]   recover_ret_i;
    logic          flush_i;

    ras_stack #(.RAS_DEPTH(16), .RAS_PTR_W(PW)) dut (
        .clock(clock), .reset(reset),
        .ras_valid_i(ras_valid_i), .ras_ctl_i(ras_ctl_i),
        .ras_br_pc_i(ras_br_pc_i), .ras_br_pos_i(ras_br_pos_i),
        .ras_tos_o(ras_tos_o), .ras_empty_o(ras_empty_o),
        .ras_ckpt_ptr_o(ras_ckpt_ptr_o), .ras_ckpt_cnt_o(ras_ckpt_cnt_o),
        .ras_ckpt_data_o(ras_ckpt_data_o),
        .recover_i(recover_i), .recover_ptr_i(recover_ptr_i),
        .recover_cnt_i(recover_cnt_i), .recover_data_i(recover_data_i),
        .recover_ctl_i(recover_ctl_i), .recover_ret_i(recover_ret_i),
        .flush_i(flush_i)
    );

    always #5 clock = ~clock;

    typedef struct {
        string         name;
        logic [63:0]   tos;
        logic          empty;
        logic [PW-1:0] ptr;
        logic [PW:0]   cnt;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(string n, string f, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got 0x%0h expected 0x%0h", n, f, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clock);
            while (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                chk(e.name, "tos",   ras_tos_o,              e.tos);
                chk(e.name, "empty", {63'd0, ras_empty_o},   {63'd0, e.empty});
                chk(e.name, "ptr",   64'(ras_ckpt_ptr_o),    64'(e.ptr));
                chk(e.name, "cnt",   64'(ras_ckpt_cnt_o),    64'(e.cnt));
                chk(e.name, "data",  ras_ckpt_data_o,        e.tos);
            end
        end
    end

    task automatic expect_st(string n, logic [63:0] tos, logic [PW-1:0] p, logic [PW:0] c);
        exp_t e;
        e.name = n; e.tos = tos; e.ptr = p; e.cnt = c; e.empty = (c == '0);
        q.push_back(e);
    endtask

    task automatic idle();
        ras_valid_i = 0; ras_ctl_i = 0; ras_br_pc_i = 0; ras_br_pos_i = 0;
        recover_i = 0; recover_ptr_i = 0; recover_cnt_i = 0; recover_data_i = 0;
        recover_ctl_i = 0; recover_ret_i = 0; flush_i = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        idle();
    endtask

    task automatic fetch(logic [1:0] ctl, logic [63:0] pc, logic [2:0] pos);
        ras_valid_i = 1; ras_ctl_i = ctl; ras_br_pc_i = pc; ras_br_pos_i = pos;
    endtask

    task automatic recover(logic [1:0] ctl, logic [PW-1:0] p, logic [PW:0] c,
                           logic [63:0] d, logic [63:0] ret);
        recover_i = 1; recover_ctl_i = ctl; recover_ptr_i = p;
        recover_cnt_i = c; recover_data_i = d; recover_ret_i = ret;
    endtask

    // Contents after 17 pushes of 0x3000+i*0x100 (pos 0): push16 in [0], push17 in [1].
    function automatic logic [63:0] stk(int p);
        if (p == 0) return 64'h4004;
        if (p == 1) return 64'h4104;
        return 64'h3004 + 64'(p * 256);
    endfunction

    initial begin
        idle();
        reset = 1;
        @(posedge clock);
        #1;
        reset = 0;
        expect_st("reset", 64'h0, 0, 0);

        fetch(2'b01, 64'h1000, 3'd2); tick(); expect_st("push1", 64'h100C, 1, 1);
        fetch(2'b01, 64'h2000, 3'd2); tick(); expect_st("push2", 64'h200C, 2, 2);
        fetch(2'b10, 0, 0);
        expect_st("pop_cycle", 64'h200C, 2, 2);
        tick(); expect_st("pop1", 64'h100C, 1, 1);
        fetch(2'b10, 0, 0); tick(); expect_st("pop2", 64'h0, 0, 0);

        for (int i = 1; i <= 17; i++) begin
            fetch(2'b01, 64'h3000 + 64'(i * 256), 3'd0);
            tick();
            expect_st($sformatf("ovf_push%0d", i), 64'h3004 + 64'(i * 256),
                      PW'(i % 16), (PW+1)'((i > 16) ? 16 : i));
        end
        for (int j = 1; j <= 16; j++) begin
            fetch(2'b10, 0, 0);
            tick();
            expect_st($sformatf("drain_pop%0d", j), stk((17 - j) % 16),
                      PW'((17 - j) % 16), (PW+1)'(16 - j));
        end
        fetch(2'b10, 0, 0); tick(); expect_st("underflow", 64'h4104, 1, 0);

        flush_i = 1; tick(); expect_st("flush", 64'h4004, 0, 0);
        fetch(2'b01, 64'h5000, 3'd1); tick();
        fetch(2'b01, 64'h5100, 3'd1); tick();
        fetch(2'b01, 64'h5200, 3'd1); tick(); expect_st("ckpt3", 64'h5208, 3, 3);
        fetch(2'b01, 64'h6000, 3'd0); tick(); expect_st("wrong_push1", 64'h6004, 4, 4);
        fetch(2'b01, 64'h6100, 3'd0); tick(); expect_st("wrong_push2", 64'h6104, 5, 5);
        fetch(2'b11, 64'h6200, 3'd0); tick(); expect_st("wrong_poppush", 64'h6204, 5, 5);

        fetch(2'b01, 64'h7000, 3'd0);
        recover(2'b10, 3, 3, 64'hA0, 64'h0);
        tick(); expect_st("recover_pop", 64'h5108, 2, 2);
        recover(2'b10, 4, 4, 64'hB4, 64'h0);
        tick(); expect_st("restored_entry3", 64'hA0, 3, 3);
        recover(2'b01, 3, 3, 64'hC3, 64'hD00);
        tick(); expect_st("replay_push", 64'hD00, 4, 4);
        fetch(2'b10, 0, 0); tick(); expect_st("replay_push_below", 64'hC3, 3, 3);
        recover(2'b11, 2, 0, 64'hE2, 64'hF00);
        tick(); expect_st("replay_poppush", 64'hF00, 2, 1);
        recover(2'b01, 5, 5, 64'h55, 64'h66);
        flush_i = 1;
        tick(); expect_st("flush_over_recover", 64'h4004, 0, 0);
        recover(2'b01, 15, 16, 64'hFF, 64'h1234);
        tick(); expect_st("replay_push_wrap", 64'h1234, 0, 16);

        fetch(2'b01, 64'h8000, 3'd7); tick(); expect_st("pre_reset_push", 64'h8020, 1, 16);
        @(negedge clock);
        #1;
        fetch(2'b01, 64'h9000, 3'd0);
        reset = 1;
        expect_st("async_reset", 64'h0, 0, 0);
        @(posedge clock);
        #1;
        reset = 0;
        idle();
        expect_st("push_lost", 64'h0, 0, 0);
        tick(); expect_st("post_reset_idle", 64'h0, 0, 0);

        repeat (2) @(negedge clock);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
